alu_bool_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-op boolean ALU slice.

---
 rtl/alu_bool_pipe.sv | 130 +++++++++++++
 tb/tb_alu_bool_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bool_pipe.sv
// Two-stage valid/ready boolean ALU: S1 captures operands, S2 computes and holds the result.
// The XOR accumulator commits only when a beat moves from S1 into S2.
module alu_bool_pipe #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_XOR     = 4'b0010;
  localparam logic [3:0] OP_NAND    = 4'b0011;
  localparam logic [3:0] OP_EQ      = 4'b0100;
  localparam logic [3:0] OP_NOR     = 4'b0101;
  localparam logic [3:0] OP_XNOR    = 4'b0110;
  localparam logic [3:0] OP_LTU     = 4'b0111;
  localparam logic [3:0] OP_ACC_XOR = 4'b1000;
  localparam logic [3:0] OP_ACC_CLR = 4'b1001;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [3:0]       s1_op_reg;
  logic             s1_en_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;
  logic [WIDTH-1:0] acc_reg;

  logic [WIDTH-1:0] result_next;
  logic             err_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] same_bits;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign accept   = in_valid && in_ready;

  // Per-bit equality, reduced below for the EQ flag.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_same
      assign same_bits[gi] = ~(s1_a_reg[gi] ^ s1_b_reg[gi]);
    end
  endgenerate

  always_comb begin
    result_next = '0;
    err_next    = 1'b0;
    acc_next    = acc_reg;
    if (s1_en_reg) begin
      case (s1_op_reg)
        OP_AND:     result_next = s1_a_reg & s1_b_reg;
        OP_OR:      result_next = s1_a_reg | s1_b_reg;
        OP_XOR:     result_next = s1_a_reg ^ s1_b_reg;
        OP_NAND:    result_next = ~(s1_a_reg & s1_b_reg);
        OP_EQ:      result_next = {{(WIDTH-1){1'b0}}, &same_bits};
        OP_NOR:     result_next = ~(s1_a_reg | s1_b_reg);
        OP_XNOR:    result_next = same_bits;
        OP_LTU:     result_next = {{(WIDTH-1){1'b0}}, (s1_a_reg < s1_b_reg)};
        OP_ACC_XOR: begin
          acc_next    = acc_reg ^ s1_a_reg;
          result_next = acc_next;
        end
        OP_ACC_CLR: begin
          acc_next    = ACC_INIT;
          result_next = ACC_INIT;
        end
        default:    err_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
      s1_en_reg    <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= A;
      s1_b_reg     <= B;
      s1_op_reg    <= opcode;
      s1_en_reg    <= en;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // A stalled output freezes result, err and the accumulator together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      acc_reg       <= ACC_INIT;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= result_next;
        err_reg    <= err_next;
        acc_reg    <= acc_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alu_bool_pipe.sv
// Bench for alu_bool_pipe: directed scenarios plus random traffic against a
// queue-based reference model of the op table and the in-order accumulator.
module tb_alu_bool_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;

  always #5 clk = ~clk;

  alu_bool_pipe #(.WIDTH(W), .ACC_INIT('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .opcode(opcode), .en(en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [W-1:0] acc_m;
  logic [W-1:0] exp_res_q[$];
  logic         exp_err_q[$];
  logic [W-1:0] obs_q[$];
  logic         obs_err_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what each accepted beat must eventually produce, in accept order.
  function automatic void model_push(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                     input logic [3:0] op, input logic ei);
    logic [W-1:0] r;
    logic         e;
    r = '0;
    e = 1'b0;
    if (ei) begin
      case (op)
        4'd0: r = ai & bi;
        4'd1: r = ai | bi;
        4'd2: r = ai ^ bi;
        4'd3: r = ~(ai & bi);
        4'd4: r = (ai == bi) ? 1 : 0;
        4'd5: r = ~(ai | bi);
        4'd6: r = ~(ai ^ bi);
        4'd7: r = (ai < bi) ? 1 : 0;
        4'd8: begin acc_m = acc_m ^ ai; r = acc_m; end
        4'd9: begin acc_m = '0; r = '0; end
        default: e = 1'b1;
      endcase
    end
    exp_res_q.push_back(r);
    exp_err_q.push_back(e);
  endfunction

  // One clock cycle: drive at negedge, sample handshakes just after.
  task automatic tick(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic [3:0] op, input logic ei, input logic ordy);
    logic [W-1:0] er;
    logic         ee;
    @(negedge clk);
    in_valid  = v;
    a         = ai;
    b         = bi;
    opcode    = op;
    en        = ei;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      $display("out result=%h err=%0b", result, err);
      obs_q.push_back(result);
      obs_err_q.push_back(err);
      if (exp_res_q.size() == 0) begin
        check_eq("sb_underflow", exp_res_q.size(), 1);
      end else begin
        er = exp_res_q.pop_front();
        ee = exp_err_q.pop_front();
        check_eq("sb_result", result, er);
        check_eq("sb_err", err, ee);
      end
    end
    if (in_valid && in_ready) begin
      accepts++;
      $display("in  op=%h en=%0b a=%h b=%h", opcode, en, a, b);
      model_push(a, b, opcode, en);
    end
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 4'h0, 1'b0, ordy);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (exp_res_q.size() != 0 || out_valid); i++) idle(1'b1);
    check_eq(tag, exp_res_q.size(), 0);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_err_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0; en = 1'b0; out_ready = 1'b1;
    acc_m = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_err", err, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // 1: XOR with latency check
    clear_obs();
    tick(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h2, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("lat_early", out_valid, 0);
    idle(1'b1);
    check_eq("lat_valid", out_valid, 1);
    check_eq("t1_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      check_eq("t1_result", obs_q[0], 32'h0FF0_0FF0);
      check_eq("t1_err", obs_err_q[0], 0);
    end

    // 2: EQ / LTU
    clear_obs();
    tick(1'b1, 32'h1234, 32'h1234, 4'h4, 1'b1, 1'b1);
    tick(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 4'h7, 1'b1, 1'b1);
    tick(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h7, 1'b1, 1'b1);
    drain("t2_drain");
    check_eq("t2_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      check_eq("t2_eq", obs_q[0], 1);
      check_eq("t2_ltu", obs_q[1], 1);
      check_eq("t2_ltu_swap", obs_q[2], 0);
    end

    // 3: accumulator chain
    clear_obs();
    tick(1'b1, 32'd1, '0, 4'h8, 1'b1, 1'b1);
    tick(1'b1, 32'd2, '0, 4'h8, 1'b1, 1'b1);
    tick(1'b1, 32'd4, '0, 4'h8, 1'b1, 1'b1);
    tick(1'b1, 32'hDEAD, '0, 4'h9, 1'b1, 1'b1);
    tick(1'b1, 32'd8, '0, 4'h8, 1'b1, 1'b1);
    drain("t3_drain");
    check_eq("t3_count", obs_q.size(), 5);
    if (obs_q.size() >= 5) begin
      check_eq("t3_acc1", obs_q[0], 1);
      check_eq("t3_acc3", obs_q[1], 3);
      check_eq("t3_acc7", obs_q[2], 7);
      check_eq("t3_clr", obs_q[3], 0);
      check_eq("t3_acc8", obs_q[4], 8);
    end

    // 4: backpressure with an ACC_XOR beat parked in S2
    clear_obs();
    accepts = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) tick(1'b1, 32'h10, '0, 4'h8, 1'b1, 1'b0);
      else        tick(1'b1, ra, rb, 4'h0, 1'b1, 1'b0);
      if (i == 2) held = result;
      if (i >= 2) check_eq("bp_in_ready", in_ready, 0);
      if (i >= 3) check_eq("bp_hold", result, held);
    end
    check_eq("bp_accepts", accepts, 2);
    tick(1'b1, 32'd1, '0, 4'h8, 1'b1, 1'b1);
    drain("t4_drain");
    check_eq("t4_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      check_eq("t4_acc", obs_q[0], 32'h18);
      check_eq("t4_acc_after", obs_q[2], 32'h19);
    end

    // 5: illegal opcode and en=0
    clear_obs();
    tick(1'b1, 32'hFFFF_FFFF, 32'h1, 4'hC, 1'b1, 1'b1);
    tick(1'b1, 32'hFFFF_FFFF, 32'h1, 4'hC, 1'b0, 1'b1);
    tick(1'b1, 32'hFF, '0, 4'h8, 1'b0, 1'b1);
    tick(1'b1, 32'h0, '0, 4'h8, 1'b1, 1'b1);
    drain("t5_drain");
    check_eq("t5_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check_eq("t5_ill_res", obs_q[0], 0);
      check_eq("t5_ill_err", obs_err_q[0], 1);
      check_eq("t5_en0_res", obs_q[1], 0);
      check_eq("t5_en0_err", obs_err_q[1], 0);
      check_eq("t5_acc_en0", obs_q[2], 0);
      check_eq("t5_acc_kept", obs_q[3], 32'h19);
    end

    // 6: reset with beats in S1 and S2
    tick(1'b1, 32'h3, '0, 4'h8, 1'b1, 1'b0);
    tick(1'b1, 32'h6, '0, 4'h8, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("t6_full", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    exp_res_q.delete();
    exp_err_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    tick(1'b1, 32'd5, '0, 4'h8, 1'b1, 1'b1);
    drain("t6_drain");
    check_eq("t6_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) check_eq("t6_acc5", obs_q[0], 5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      tick($urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
